// File: rtl/adder_arbiter_if.sv
// Bundle of request, shared-adder and response signals around adder_arbiter.
// Optional Rsp_ovf member exists only when ADDER_ARBITER_OVF_EN is defined.
interface adder_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]   Req_valid;
  logic [4*N_REQ-1:0] Req_A;
  logic [4*N_REQ-1:0] Req_B;
  logic [N_REQ-1:0]   Req_ready;
  logic [3:0]         Add_A;
  logic [3:0]         Add_B;
  logic [7:0]         Add_Sum;
  logic               Rsp_valid;
  logic               Rsp_ready;
  logic [ID_W-1:0]    Rsp_id;
  logic [7:0]         Rsp_sum;
`ifdef ADDER_ARBITER_OVF_EN
  logic               Rsp_ovf;
`endif

  // Environment side: requesters, the external adder and the response sink.
  modport master (
    output Req_valid, Req_A, Req_B, Add_Sum, Rsp_ready,
    input  Req_ready, Add_A, Add_B, Rsp_valid, Rsp_id, Rsp_sum
`ifdef ADDER_ARBITER_OVF_EN
    , input Rsp_ovf
`endif
  );

  modport slave (
    input  Req_valid, Req_A, Req_B, Add_Sum, Rsp_ready,
    output Req_ready, Add_A, Add_B, Rsp_valid, Rsp_id, Rsp_sum
`ifdef ADDER_ARBITER_OVF_EN
    , output Rsp_ovf
`endif
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one external 4-bit adder among N_REQ requesters.
// Define ADDER_ARBITER_OVF_EN to add the Rsp_ovf response flag.
module adder_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic           Clk,
  input  logic           Rst_n,
  adder_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]       state;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  grant;
  logic             found;
  logic [N_REQ-1:0] ready_vec;
  logic [3:0]       sel_a;
  logic [3:0]       sel_b;
  logic [ID_W-1:0]  next_ptr;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             rsp_valid;
  logic [ID_W-1:0]  rsp_id;
  logic [7:0]       rsp_sum;
`ifdef ADDER_ARBITER_OVF_EN
  logic             rsp_ovf;
`endif

  function automatic logic [ID_W-1:0] rot_idx(input logic [ID_W-1:0] p, input int k);
    int j;
    j = int'(p) + k;
    if (j >= N_REQ) j = j - N_REQ;
    return j[ID_W-1:0];
  endfunction

  // Scanning from the far end lets the candidate nearest the pointer win last.
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.Req_valid[rot_idx(ptr, k)]) begin
        found = 1'b1;
        grant = rot_idx(ptr, k);
      end
    end
  end

  // Gated by Rst_n so no requester sees a handshake that reset would discard.
  always_comb begin
    ready_vec = '0;
    if (state == IDLE && Rst_n && found) ready_vec[grant] = 1'b1;
  end

  assign sel_a    = bus.Req_A[{grant, 2'b00} +: 4];
  assign sel_b    = bus.Req_B[{grant, 2'b00} +: 4];
  assign next_ptr = (rsp_id == ID_W'(N_REQ - 1)) ? '0 : rsp_id + 1'b1;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      add_a     <= '0;
      add_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
`ifdef ADDER_ARBITER_OVF_EN
      rsp_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            add_a  <= sel_a;
            add_b  <= sel_b;
            rsp_id <= grant;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          rsp_sum   <= bus.Add_Sum;
`ifdef ADDER_ARBITER_OVF_EN
          rsp_ovf   <= bus.Add_Sum[4];
`endif
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (bus.Rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr       <= next_ptr;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Req_ready = ready_vec;
  assign bus.Add_A     = add_a;
  assign bus.Add_B     = add_b;
  assign bus.Rsp_valid = rsp_valid;
  assign bus.Rsp_id    = rsp_id;
  assign bus.Rsp_sum   = rsp_sum;
`ifdef ADDER_ARBITER_OVF_EN
  assign bus.Rsp_ovf   = rsp_ovf;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a transaction-level reference model.
// Honours ADDER_ARBITER_OVF_EN for the Rsp_ovf checks.
module tb_adder_arbiter;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  adder_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

  adder_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (bus.slave)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // The shared adder lives outside the arbiter.
  assign bus.Add_Sum = {4'b0000, bus.Add_A} + {4'b0000, bus.Add_B};

  // Reference model state: one outstanding transaction at most.
  bit              mBusy     = 1'b0;
  bit              mRspValid = 1'b0;
  bit              mOvf      = 1'b0;
  logic [ID_W-1:0] mPtr      = '0;
  logic [ID_W-1:0] mId       = '0;
  logic [3:0]      mA        = '0;
  logic [3:0]      mB        = '0;
  logic [7:0]      mSum      = '0;
  logic [7:0]      mPend     = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N_REQ-1:0] v, input int p);
    for (int k = 0; k < N_REQ; k++)
      if (v[(p + k) % N_REQ]) return (p + k) % N_REQ;
    return -1;
  endfunction

  // Compare against the model mid-cycle, then advance it to the next cycle.
  initial begin
    int g;
    logic [N_REQ-1:0] expReady;
    @(posedge Clk);
    forever begin
      @(negedge Clk);
      g = pick(bus.Req_valid, int'(mPtr));
      expReady = '0;
      if (Rst_n && !mBusy && g >= 0) expReady[g] = 1'b1;
      checkOutput("m_req_ready", 32'(bus.Req_ready), 32'(expReady));
      checkOutput("m_rsp_valid", 32'(bus.Rsp_valid), 32'(mRspValid));
      checkOutput("m_rsp_id",    32'(bus.Rsp_id),    32'(mId));
      checkOutput("m_rsp_sum",   32'(bus.Rsp_sum),   32'(mSum));
      checkOutput("m_add_a",     32'(bus.Add_A),     32'(mA));
      checkOutput("m_add_b",     32'(bus.Add_B),     32'(mB));
`ifdef ADDER_ARBITER_OVF_EN
      checkOutput("m_rsp_ovf",   32'(bus.Rsp_ovf),   32'(mOvf));
`endif
      if (!Rst_n) begin
        mBusy = 1'b0; mRspValid = 1'b0; mOvf = 1'b0;
        mPtr = '0; mId = '0; mA = '0; mB = '0; mSum = '0;
      end else if (!mBusy) begin
        if (g >= 0) begin
          mBusy = 1'b1;
          mId   = g[ID_W-1:0];
          mA    = bus.Req_A[4*g +: 4];
          mB    = bus.Req_B[4*g +: 4];
          mPend = {4'b0000, mA} + {4'b0000, mB};
        end
      end else if (!mRspValid) begin
        mRspValid = 1'b1;
        mSum      = mPend;
        mOvf      = mPend[4];
      end else if (bus.Rsp_ready) begin
        mRspValid = 1'b0;
        mBusy     = 1'b0;
        mPtr      = ID_W'((int'(mId) + 1) % N_REQ);
      end
    end
  end

  task automatic applyStimulus(input logic [N_REQ-1:0] v, input logic [15:0] a,
                               input logic [15:0] b, input logic rr);
    @(posedge Clk); #1;
    bus.Req_valid = v;
    bus.Req_A     = a;
    bus.Req_B     = b;
    bus.Rsp_ready = rr;
  endtask

  task automatic waitGrant(input logic [N_REQ-1:0] mask, input string name, output int at);
    at = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge Clk);
      if (bus.Req_ready !== '0) break;
    end
    if (bus.Req_ready === '0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: no grant seen, want %b", name, mask);
    end else begin
      checkOutput(name, 32'(bus.Req_ready), 32'(mask));
      at = cyc;
    end
  endtask

  task automatic expectTxn(input logic [N_REQ-1:0] mask, input int id, input int sum,
                           input logic [N_REQ-1:0] drop, input string name, output int at);
    waitGrant(mask, {name, "_grant"}, at);
    @(posedge Clk); #1;
    bus.Req_valid = bus.Req_valid & ~drop;
    @(negedge Clk);
    checkOutput({name, "_issue_valid"}, 32'(bus.Rsp_valid), 0);
    @(negedge Clk);
    checkOutput({name, "_valid"}, 32'(bus.Rsp_valid), 1);
    checkOutput({name, "_id"},    32'(bus.Rsp_id),    32'(id));
    checkOutput({name, "_sum"},   32'(bus.Rsp_sum),   32'(sum));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t0, t1, t2, t3, t4, rise, seen;
    bus.Req_valid = 4'b1111;
    bus.Req_A     = 16'h3210;
    bus.Req_B     = 16'h3210;
    bus.Rsp_ready = 1'b1;
    Rst_n         = 1'b0;

    // Reset held two cycles with every requester asking.
    repeat (2) begin
      @(negedge Clk);
      checkOutput("rst_req_ready", 32'(bus.Req_ready), 0);
      checkOutput("rst_rsp_valid", 32'(bus.Rsp_valid), 0);
      checkOutput("rst_add_a",     32'(bus.Add_A),     0);
      checkOutput("rst_rsp_sum",   32'(bus.Rsp_sum),   0);
    end
    @(posedge Clk); #1;
    Rst_n = 1'b1;

    // Round robin with all four valid, A=B=i.
    expectTxn(4'b0001, 0, 0, 4'b0000, "rr0", t0);
    expectTxn(4'b0010, 1, 2, 4'b0000, "rr1", t1);
    expectTxn(4'b0100, 2, 4, 4'b0000, "rr2", t2);
    expectTxn(4'b1000, 3, 6, 4'b0000, "rr3", t3);
    expectTxn(4'b0001, 0, 0, 4'b1111, "rr4", t4);
    checkOutput("rr_gap01", 32'(t1 - t0), 3);
    checkOutput("rr_gap12", 32'(t2 - t1), 3);
    checkOutput("rr_gap23", 32'(t3 - t2), 3);
    checkOutput("rr_gap34", 32'(t4 - t3), 3);

    // Single request from requester 2: 7 + 9 = 16.
    applyStimulus(4'b0100, 16'h0700, 16'h0900, 1'b1);
    expectTxn(4'b0100, 2, 16, 4'b0100, "single", t0);
`ifdef ADDER_ARBITER_OVF_EN
    checkOutput("single_ovf", 32'(bus.Rsp_ovf), 1);
`endif

    // Pointer now 3; only requesters 1 and 3 valid.
    applyStimulus(4'b1010, 16'h2010, 16'h3040, 1'b1);
    expectTxn(4'b1000, 3, 5, 4'b1000, "skip3", t0);
    expectTxn(4'b0010, 1, 5, 4'b0010, "skip1", t1);
    checkOutput("skip_gap", 32'(t1 - t0), 3);

    // Backpressure: 15 + 15 held for five stalled cycles.
    applyStimulus(4'b0011, 16'h002F, 16'h003F, 1'b0);
    expectTxn(4'b0001, 0, 30, 4'b0001, "bp", t0);
    repeat (4) begin
      @(negedge Clk);
      checkOutput("bp_stall_ready", 32'(bus.Req_ready), 0);
      checkOutput("bp_stall_valid", 32'(bus.Rsp_valid), 1);
      checkOutput("bp_stall_id",    32'(bus.Rsp_id),    0);
      checkOutput("bp_stall_sum",   32'(bus.Rsp_sum),   30);
    end
    @(posedge Clk); #1;
    bus.Rsp_ready = 1'b1;
    @(negedge Clk);
    checkOutput("bp_accept_ready", 32'(bus.Req_ready), 0);
    rise = cyc;
    waitGrant(4'b0010, "bp_next", t1);
    checkOutput("bp_next_gap", 32'(t1 - rise), 1);

    // Let requester 1 reach the response stage, then reset in the middle of it.
    @(posedge Clk); #1;
    bus.Req_valid = 4'b0000;
    bus.Rsp_ready = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    checkOutput("mid_valid", 32'(bus.Rsp_valid), 1);
    checkOutput("mid_sum",   32'(bus.Rsp_sum),   5);
    @(posedge Clk); #1;
    Rst_n = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    bus.Rsp_ready = 1'b1;
    @(negedge Clk);
    checkOutput("mid_rst_valid", 32'(bus.Rsp_valid), 0);
    checkOutput("mid_rst_id",    32'(bus.Rsp_id),    0);
    seen = 0;
    repeat (5) begin
      @(negedge Clk);
      if (bus.Rsp_valid === 1'b1) seen++;
    end
    checkOutput("mid_no_rsp", 32'(seen), 0);

    // Pointer back at 0 after reset, so requester 0 wins over 1.
    applyStimulus(4'b0011, 16'h002F, 16'h003F, 1'b1);
    expectTxn(4'b0001, 0, 30, 4'b0011, "post_rst", t0);
`ifdef ADDER_ARBITER_OVF_EN
    checkOutput("post_rst_ovf", 32'(bus.Rsp_ovf), 1);
`endif
    @(negedge Clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one combinational 4-bit adder (operands A, B; 8-bit Sum) among N_REQ requesters.
- Round-robin grant; registered operand issue; registered result with requester ID on a valid/ready response channel.
- Sits between the requesting lab blocks and the single adder instance; the adder is external, driven through Add_A/Add_B and read back on Add_Sum.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of Rsp_id; must satisfy 2**ID_W >= N_REQ.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  synchronous active-low reset.
- Req_valid  input  N_REQ  per-requester request valid.
- Req_A  input  4*N_REQ  operand A; requester i uses bits [4i+3:4i].
- Req_B  input  4*N_REQ  operand B, same packing.
- Req_ready  output  N_REQ  one-hot accept strobe; at most one bit high per cycle.
- Add_A  output  4  operand A to the shared adder.
- Add_B  output  4  operand B to the shared adder.
- Add_Sum  input  8  result from the shared adder.
- Rsp_valid  output  1  response valid.
- Rsp_ready  input  1  downstream accepts response.
- Rsp_id  output  ID_W  index of the requester that owns the response.
- Rsp_sum  output  8  registered sum.

Behaviour:
- One clock (Clk); reset synchronous, active-low (Rst_n), sampled on rising edge only.
- Reset values: state=IDLE, Req_ready=0, Add_A=0, Add_B=0, Rsp_valid=0, Rsp_id=0, Rsp_sum=0, round-robin pointer=0.
- Reset asserted mid-operation abandons any in-flight request and response; no response is produced for it.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any Req_valid is set, grant the first set bit searching from the pointer upward with wrap (N_REQ-1 wraps to 0).
  - Req_ready[grant]=1 combinationally in this cycle; the handshake completes this cycle.
  - Latch that requester's A/B into Add_A/Add_B and grant into Rsp_id; go to ISSUE.
  - No valid requests: stay in IDLE; Req_ready=0.
- ISSUE:
  - Add_A/Add_B are stable; capture Add_Sum into Rsp_sum; set Rsp_valid=1; go to RESP.
  - Req_ready=0.
- RESP:
  - Hold Rsp_valid, Rsp_id and Rsp_sum stable until Rsp_ready=1.
  - On a cycle with Rsp_valid & Rsp_ready: clear Rsp_valid, set pointer=(Rsp_id+1) mod N_REQ, go to IDLE.
  - Req_ready=0 throughout.
- Latency and throughput:
  - Accept at cycle T gives Rsp_valid at T+2.
  - Peak throughput is one transaction per 3 cycles; Rsp_ready held high gives back-to-back grants every 3 cycles.
- Add_A/Add_B hold their last values outside ISSUE (no glitching to 0).
- Requester rules:
  - Each requester must hold Req_valid and its operands until its Req_ready bit is seen.
  - Dropping Req_valid before grant is allowed; the block makes no claim on that request.
- Width: Rsp_sum = zero-extended A+B; maximum 15+15=30 (8'h1E); bits [7:5] are always 0.
- Simultaneous requests: resolved strictly by the round-robin pointer.
- Starvation: with all requesters continuously valid, each is granted once per N_REQ grants.

Optional Feature:
- Macro: ADDER_ARBITER_OVF_EN.
- Defined:
  - Adds output port Rsp_ovf (1 bit); reset value 0.
  - Captured in ISSUE as Add_Sum[4], i.e. the sum exceeds the 4-bit range.
  - Held stable with Rsp_sum while in RESP.
- Not defined: port absent; all other behaviour identical.

Test Plan:
- Reset: drive Rst_n=0 for 2 cycles with Req_valid=4'b1111 -> all outputs 0, no Req_ready pulse; after release, first grant goes to requester 0.
- Single request: requester 2 with A=4'd7, B=4'd9; Rsp_ready=1 -> Req_ready=4'b0100 at T; Rsp_valid at T+2 with Rsp_id=2, Rsp_sum=8'd16 (Rsp_ovf=1 if enabled).
- Round-robin: all four continuously valid with A=i, B=i; Rsp_ready=1 -> grant order 0,1,2,3,0; sums 0,2,4,6; grants 3 cycles apart.
- Backpressure: Rsp_ready=0 for 5 cycles after Rsp_valid (A=15, B=15) -> Rsp_sum=8'd30 and Rsp_id held stable; no Req_ready during stall; next grant one cycle after Rsp_ready rises.
- Wrap and skip: pointer=3, only requesters 1 and 3 valid -> grant 3, then 1.
- Mid-operation reset: assert Rst_n=0 in RESP -> next cycle Rsp_valid=0 and state IDLE; that response is never delivered.
